// File: rtl/lsb_pkg.sv
// rtl/lsb_pkg.sv - op encodings, FSM states and op decode helpers for the load/store queue
package lsb_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } fsm_e;

    function automatic logic [2:0] op_bytes(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
            default:              op_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        is_store = (op >= OP_SB);
    endfunction

endpackage

// File: rtl/lsb_mem_seq.sv
// rtl/lsb_mem_seq.sv - serialises one load/store into byte accesses and assembles load data
module lsb_mem_seq
    import lsb_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic        done,
    output logic [31:0] rdata
);
    logic        active;
    logic        st_q;
    logic [2:0]  op_q;
    logic [2:0]  nb_q;
    logic [2:0]  cnt_q;
    logic [31:0] wd_q;
    logic [31:0] buf_q;
    logic [31:0] asm_w;
    logic [2:0]  nxt;

    assign nxt  = cnt_q + 3'd1;
    // Stores finish on their last write cycle; loads need one more cycle for the final byte to return.
    assign done = active && rdy_in && (st_q ? (nxt == nb_q) : (cnt_q == nb_q));

    always_comb begin
        asm_w = buf_q;
        case (nb_q)
            3'd1:    asm_w[7:0]   = mem_din;
            3'd2:    asm_w[15:8]  = mem_din;
            default: asm_w[31:24] = mem_din;
        endcase
        case (op_q)
            OP_LB:   rdata = {{24{asm_w[7]}}, asm_w[7:0]};
            OP_LBU:  rdata = {24'h0, asm_w[7:0]};
            OP_LH:   rdata = {{16{asm_w[15]}}, asm_w[15:0]};
            OP_LHU:  rdata = {16'h0, asm_w[15:0]};
            default: rdata = asm_w;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active   <= 1'b0;
            st_q     <= 1'b0;
            op_q     <= 3'd0;
            nb_q     <= 3'd0;
            cnt_q    <= 3'd0;
            wd_q     <= 32'h0;
            buf_q    <= 32'h0;
            mem_a    <= 32'h0;
            mem_dout <= 8'h0;
            mem_wr   <= 1'b0;
        end else if (rdy_in) begin
            if (start) begin
                active   <= 1'b1;
                st_q     <= is_store(op);
                op_q     <= op;
                nb_q     <= op_bytes(op);
                cnt_q    <= 3'd0;
                buf_q    <= 32'h0;
                wd_q     <= wdata;
                mem_a    <= addr;
                mem_dout <= wdata[7:0];
                mem_wr   <= is_store(op);
            end else if (active) begin
                if (done || (abort && !st_q)) begin
                    active <= 1'b0;
                    mem_wr <= 1'b0;
                end else begin
                    cnt_q <= nxt;
                    if (nxt != nb_q) begin
                        mem_a    <= mem_a + 32'd1;
                        mem_dout <= wd_q[15:8];
                        wd_q     <= {8'h00, wd_q[31:8]};
                        mem_wr   <= st_q;
                    end else begin
                        mem_wr <= 1'b0;
                    end
                    if (!st_q) begin
                        case (cnt_q)
                            3'd1:    buf_q[7:0]   <= mem_din;
                            3'd2:    buf_q[15:8]  <= mem_din;
                            3'd3:    buf_q[23:16] <= mem_din;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lsb_queue.sv
// rtl/lsb_queue.sv - in-order load/store queue ring with issue eligibility, flush and occupancy
module lsb_queue
    import lsb_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          ROB_WIDTH   = 4,
    parameter int          FULL_MARGIN = 3,
    parameter logic [31:0] IO_ADDR     = 32'h30000,
    localparam int         DEPTH_W     = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 disp_valid,
    input  logic [ROB_WIDTH-1:0] disp_tag,
    input  logic                 rs_valid,
    input  logic [2:0]           rs_op,
    input  logic [ROB_WIDTH-1:0] rs_tag,
    input  logic [31:0]          rs_wdata,
    input  logic [31:0]          rs_addr,
    input  logic                 commit_valid,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    input  logic [7:0]           mem_din,
    input  logic                 io_buffer_full,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr,
    output logic                 full_out,
    output logic [DEPTH_W:0]     count_out,
    output logic                 rob_valid,
    output logic [ROB_WIDTH-1:0] rob_tag,
    output logic [31:0]          rob_data
);
    localparam logic [DEPTH_W:0]   FULL_CNT = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

    logic [ROB_WIDTH-1:0] tag_q   [DEPTH];
    logic [2:0]           op_q    [DEPTH];
    logic [31:0]          addr_q  [DEPTH];
    logic [31:0]          wdata_q [DEPTH];
    logic [DEPTH-1:0]     valid_q, ready_q, comm_q;
    logic [DEPTH_W-1:0]   head_q, tail_q, head_d, tail_d, idx;
    logic [DEPTH_W:0]     count_q, count_d, kept;
    logic [DEPTH-1:0]     keep;
    fsm_e                 state_q, state_d;
    logic                 head_io, head_st, eligible, issue, retire, accept, load_end, run;
    logic                 seq_done;
    logic [31:0]          seq_rdata;

    assign count_out = count_q;

    always_comb begin
        head_io = (addr_q[head_q] == IO_ADDR);
        head_st = is_store(op_q[head_q]);
        if (head_st) eligible = comm_q[head_q] && !(head_io && io_buffer_full);
        else         eligible = !head_io || (comm_q[head_q] && !io_buffer_full);
        issue    = rdy_in && !clear_in && (state_q == IDLE) && valid_q[head_q] && ready_q[head_q] && eligible;
        load_end = seq_done && (state_q == LOAD) && !clear_in;
        retire   = seq_done && ((state_q == STORE) || load_end);
        accept   = rdy_in && !clear_in && disp_valid && ((count_q != FULL_CNT) || retire);

        // Committed entries form a contiguous run from head; a flush keeps exactly that run.
        keep = '0;
        kept = '0;
        run  = 1'b1;
        idx  = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + DEPTH_W'(k);
            if (run && valid_q[idx] && (comm_q[idx] || (commit_valid && tag_q[idx] == commit_tag))) begin
                keep[idx] = 1'b1;
                kept      = kept + CNT_ONE;
            end else begin
                run = 1'b0;
            end
        end

        head_d  = retire ? head_q + PTR_ONE : head_q;
        if (rdy_in && clear_in) begin
            tail_d  = head_q + kept[DEPTH_W-1:0];
            count_d = retire ? kept - CNT_ONE : kept;
        end else begin
            tail_d  = accept ? tail_q + PTR_ONE : tail_q;
            count_d = count_q + (accept ? CNT_ONE : '0) - (retire ? CNT_ONE : '0);
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = head_st ? STORE : LOAD;
            LOAD:    if (seq_done || (rdy_in && clear_in)) state_d = IDLE;
            STORE:   if (seq_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            ready_q   <= '0;
            comm_q    <= '0;
            full_out  <= 1'b0;
            rob_valid <= 1'b0;
            rob_tag   <= '0;
            rob_data  <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]   <= '0;
                op_q[i]    <= 3'd0;
                addr_q[i]  <= 32'h0;
                wdata_q[i] <= 32'h0;
            end
        end else if (rdy_in) begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_out  <= (32'(count_d) + FULL_MARGIN) >= DEPTH;
            rob_valid <= load_end;
            if (load_end) begin
                rob_tag  <= tag_q[head_q];
                rob_data <= seq_rdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && commit_valid && tag_q[i] == commit_tag)
                    comm_q[i] <= 1'b1;
                if (!clear_in && valid_q[i] && rs_valid && tag_q[i] == rs_tag) begin
                    ready_q[i] <= 1'b1;
                    op_q[i]    <= rs_op;
                    addr_q[i]  <= rs_addr;
                    wdata_q[i] <= rs_wdata;
                end
            end
            if (clear_in) valid_q <= keep;
            if (retire)   valid_q[head_q] <= 1'b0;
            // Written last so a slot freed by retire this edge can be refilled on the same edge.
            if (accept) begin
                valid_q[tail_q] <= 1'b1;
                tag_q[tail_q]   <= disp_tag;
                ready_q[tail_q] <= 1'b0;
                comm_q[tail_q]  <= 1'b0;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(rdy_in && !clear_in && disp_valid && count_q == FULL_CNT && !retire));

    lsb_mem_seq u_seq (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .start    (issue),
        .abort    (clear_in),
        .op       (op_q[head_q]),
        .addr     (addr_q[head_q]),
        .wdata    (wdata_q[head_q]),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .done     (seq_done),
        .rdata    (seq_rdata)
    );

endmodule

// File: tb/tb_lsb_queue.sv
// tb/tb_lsb_queue.sv - directed vectors for lsb_queue with a byte memory model
module tb_lsb_queue;
    import lsb_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        disp_valid = 1'b0;
    logic [3:0]  disp_tag = 4'h0;
    logic        rs_valid = 1'b0;
    logic [2:0]  rs_op = 3'd0;
    logic [3:0]  rs_tag = 4'h0;
    logic [31:0] rs_wdata = 32'h0;
    logic [31:0] rs_addr = 32'h0;
    logic        commit_valid = 1'b0;
    logic [3:0]  commit_tag = 4'h0;
    logic [7:0]  mem_din = 8'h0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        full_out;
    logic [3:0]  count_out;
    logic        rob_valid;
    logic [3:0]  rob_tag;
    logic [31:0] rob_data;

    always #5 clk_in = ~clk_in;

    lsb_queue #(.DEPTH(8), .ROB_WIDTH(4), .FULL_MARGIN(3), .IO_ADDR(32'h30000)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_tag(disp_tag),
        .rs_valid(rs_valid), .rs_op(rs_op), .rs_tag(rs_tag), .rs_wdata(rs_wdata), .rs_addr(rs_addr),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .full_out(full_out), .count_out(count_out),
        .rob_valid(rob_valid), .rob_tag(rob_tag), .rob_data(rob_data)
    );

    int vec_cnt = 0;
    int miscmp  = 0;
    int cyc     = 0;

    logic [7:0]  mem_model [logic [31:0]];
    int          first_cyc [logic [31:0]];
    logic [31:0] wr_a [$];
    logic [7:0]  wr_d [$];
    int          wr_c [$];
    logic [3:0]  rt_q [$];
    logic [31:0] rd_q [$];

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (mem_wr) begin
            wr_a.push_back(mem_a);
            wr_d.push_back(mem_dout);
            wr_c.push_back(cyc);
            mem_model[mem_a] = mem_dout;
        end
        mem_din <= mem_model.exists(mem_a) ? mem_model[mem_a] : 8'h00;
    end

    always @(negedge clk_in) begin
        if (!first_cyc.exists(mem_a)) first_cyc[mem_a] = cyc;
        if (rob_valid) begin
            rt_q.push_back(rob_tag);
            rd_q.push_back(rob_data);
        end
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic disp(input logic [3:0] t);
        disp_valid = 1'b1; disp_tag = t;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic rs(input logic [3:0] t, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        rs_valid = 1'b1; rs_tag = t; rs_op = op; rs_addr = a; rs_wdata = d;
        step();
        rs_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] t);
        commit_valid = 1'b1; commit_tag = t;
        step();
        commit_valid = 1'b0;
    endtask

    task automatic wait_rob(input string name, output logic [31:0] d, output logic [3:0] t, output int at);
        at = -1; d = 32'h0; t = 4'h0;
        for (int i = 0; i < 40 && at < 0; i++) begin
            step();
            if (rob_valid) begin
                d = rob_data; t = rob_tag; at = cyc;
            end
        end
        check_val({name, "_seen"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic do_load(input string name, input logic [3:0] t, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [3:0]  gt;
        int          at;
        disp(t);
        rs(t, op, a, 32'h0);
        wait_rob(name, d, gt, at);
        check_val(name, d, exp);
        check_val({name, "_tag"}, 32'(gt), 32'(t));
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (count_out != 4'd0 && n < 60) begin
            step();
            n++;
        end
        check_val({name, "_drained"}, 32'(count_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  gt;
        int          at;
        int          n0;
        logic [31:0] w;

        mem_model[32'h100] = 8'h11; mem_model[32'h101] = 8'h22;
        mem_model[32'h102] = 8'h33; mem_model[32'h103] = 8'h44;
        mem_model[32'h200] = 8'h80;
        mem_model[32'h300] = 8'h80; mem_model[32'h301] = 8'hFF;
        mem_model[32'h30000] = 8'h5A;
        for (int t = 0; t <= 8; t++) mem_model[32'h400 + t] = 8'(t + 16);

        step(); step();
        check_val("rst_count", 32'(count_out), 32'd0);
        check_val("rst_full",  32'(full_out),  32'd0);
        check_val("rst_mem_wr", 32'(mem_wr),   32'd0);
        check_val("rst_mem_a", mem_a,          32'h0);
        check_val("rst_rob_valid", 32'(rob_valid), 32'd0);
        rst_n_in = 1'b1;
        step();

        // LW latency and little-endian assembly
        disp(4'd1);
        check_val("lw_count1", 32'(count_out), 32'd1);
        rs(4'd1, OP_LW, 32'h100, 32'h0);
        wait_rob("lw", d, gt, at);
        check_val("lw_data", d, 32'h44332211);
        check_val("lw_latency", 32'(at - first_cyc[32'h100]), 32'd5);
        check_val("lw_count0", 32'(count_out), 32'd0);

        // sign / zero extension
        do_load("lb",  4'd2, OP_LB,  32'h200, 32'hFFFFFF80);
        do_load("lbu", 4'd3, OP_LBU, 32'h200, 32'h00000080);
        do_load("lh",  4'd4, OP_LH,  32'h300, 32'hFFFFFF80);
        do_load("lhu", 4'd5, OP_LHU, 32'h300, 32'h0000FF80);

        // store waits for commit, then writes 4 consecutive bytes
        step();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        disp(4'd3);
        rs(4'd3, OP_SW, 32'h10, 32'hDEADBEEF);
        repeat (6) step();
        check_val("sw_no_write_precommit", 32'(wr_a.size()), 32'd0);
        check_val("sw_count_held", 32'(count_out), 32'd1);
        commit(4'd3);
        wait_empty("sw");
        step();
        check_val("sw_nwrites", 32'(wr_a.size()), 32'd4);
        w = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("sw_addr%0d", k), wr_a[k], 32'h10 + 32'(k));
            check_val($sformatf("sw_byte%0d", k), 32'(wr_d[k]), 32'(8'(w >> (8 * k))));
        end
        check_val("sw_back_to_back", 32'(wr_c[3] - wr_c[0]), 32'd3);

        // IO load held for commit and for io_buffer_full
        disp(4'd4);
        rs(4'd4, OP_LB, 32'h30000, 32'h0);
        repeat (6) step();
        check_val("io_no_access_uncommitted", 32'(first_cyc.exists(32'h30000)), 32'd0);
        io_buffer_full = 1'b1;
        commit(4'd4);
        repeat (6) step();
        check_val("io_no_access_busy", 32'(first_cyc.exists(32'h30000)), 32'd0);
        io_buffer_full = 1'b0;
        wait_rob("io_lb", d, gt, at);
        check_val("io_lb_data", d, 32'h0000005A);
        check_val("io_lb_tag", 32'(gt), 32'd4);
        step();

        // fill all slots, then dispatch on the retire edge, then drain across the wrap
        for (int t = 0; t < 8; t++) begin
            disp(4'(t));
            check_val($sformatf("fill_count%0d", t + 1), 32'(count_out), 32'(t + 1));
            check_val($sformatf("fill_full%0d", t + 1), 32'(full_out), 32'((t + 1 + 3) >= 8));
        end
        rs(4'd0, OP_LB, 32'h400, 32'h0);
        for (int i = 0; i < 20 && mem_a != 32'h400; i++) step();
        step();
        disp_valid = 1'b1; disp_tag = 4'd8;
        step();
        disp_valid = 1'b0;
        check_val("wrap_rob_valid", 32'(rob_valid), 32'd1);
        check_val("wrap_rob_tag", 32'(rob_tag), 32'd0);
        check_val("wrap_count_stays", 32'(count_out), 32'd8);
        for (int t = 1; t <= 8; t++) rs(4'(t), OP_LB, 32'h400 + 32'(t), 32'h0);
        wait_empty("wrap");
        step(); step();
        n0 = rt_q.size() - 8;
        for (int t = 1; t <= 8; t++) begin
            check_val($sformatf("wrap_order_tag%0d", t), 32'(rt_q[n0 + t - 1]), 32'(t));
            check_val($sformatf("wrap_order_data%0d", t), rd_q[n0 + t - 1], 32'(t + 16));
        end

        // flush keeps the committed in-flight store, drops the rest
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        disp(4'd1); disp(4'd2); disp(4'd3);
        rs(4'd2, OP_LW, 32'h500, 32'h0);
        rs(4'd3, OP_SB, 32'h600, 32'h77);
        rs(4'd1, OP_SW, 32'h20, 32'h11223344);
        commit(4'd1);
        for (int i = 0; i < 20 && !mem_wr; i++) step();
        n0 = rt_q.size();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        check_val("flush_count1", 32'(count_out), 32'd1);
        wait_empty("flush");
        repeat (8) step();
        check_val("flush_nwrites", 32'(wr_a.size()), 32'd4);
        check_val("flush_wr_addr3", wr_a[3], 32'h23);
        check_val("flush_wr_byte0", 32'(wr_d[0]), 32'h44);
        check_val("flush_no_rob", 32'(rt_q.size() - n0), 32'd0);
        check_val("flush_lw_dropped", 32'(first_cyc.exists(32'h500)), 32'd0);
        check_val("flush_sb_dropped", 32'(first_cyc.exists(32'h600)), 32'd0);
        check_val("flush_count_end", 32'(count_out), 32'd0);

        // reset during a store truncates the write immediately
        disp(4'd5);
        rs(4'd5, OP_SW, 32'h40, 32'hA5A5A5A5);
        commit(4'd5);
        for (int i = 0; i < 20 && !mem_wr; i++) step();
        check_val("midrst_store_active", 32'(mem_wr), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check_val("midrst_mem_wr", 32'(mem_wr), 32'd0);
        check_val("midrst_count", 32'(count_out), 32'd0);
        check_val("midrst_mem_a", mem_a, 32'h0);
        step();
        rst_n_in = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
